// File: rtl/cc_frame_sequencer_pkg.sv
// Shared types and helpers for the frame sequencer slice.
// The sequencer state enum and a width helper that never returns zero.
package cc_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } SeqState;

  // Index width for n items, at least one bit so single-stage builds still have a port.
  function automatic int clog2min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cc_trigger_delay.sv
// Delays the frame trigger strobe by DELAY clock cycles.
// DELAY = 0 degenerates to a plain wire.
module cc_trigger_delay #(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic delayed
);

  generate
    if (DELAY == 0) begin : g_pass
      assign delayed = trigger;
    end else begin : g_shift
      logic [DELAY-1:0] shift;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shift <= '0;
        end else begin
          shift <= (shift << 1) | DELAY'(trigger);
        end
      end

      assign delayed = shift[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/cc_frame_sequencer.sv
// Frame sequencer: delays and decimates the sample-read strobe, then starts each
// downstream stage in turn, with drop accounting and a per-stage watchdog.
module cc_frame_sequencer
  import cc_frame_sequencer_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int DELAY     = 4,
  parameter int DECIM_W   = 4,
  parameter int TIMEOUT_W = 20,
  parameter int CNT_W     = 16,
  localparam int STAGE_W  = clog2min1(STAGES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decimate,
  input  logic [STAGES-1:0]  stageDone,
  input  logic               clearErr,
  output logic [STAGES-1:0]  stageStart,
  output logic               busy,
  output logic               frameDone,
  output logic [CNT_W-1:0]   dropCount,
  output logic               timeoutErr,
  output logic [STAGE_W-1:0] timeoutStage
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);
  // The START cycle and the flag register stage are pre-counted, so the error
  // appears exactly 2^TIMEOUT_W-1 cycles after the stage start pulse.
  localparam logic [TIMEOUT_W-1:0] WD_PRELOAD = TIMEOUT_W'(2);

  logic d_trig;
  logic fire;
  logic drop;
  logic done_cur;
  logic frame_done_nxt;
  logic timeout_hit;

  logic [DECIM_W-1:0]   dec_cnt;
  logic [STAGE_W-1:0]   stage, stage_nxt;
  logic [TIMEOUT_W-1:0] wd, wd_nxt;
  logic [STAGES-1:0]    stage_mask;
  SeqState              state, state_nxt;

  cc_trigger_delay #(
    .DELAY(DELAY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .delayed (d_trig)
  );

  // A counter already past a freshly lowered decimate value fires on the next strobe.
  assign fire = d_trig && enable && (dec_cnt >= decimate);
  assign drop = fire && (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
    end else if (!enable) begin
      dec_cnt <= '0;
    end else if (d_trig) begin
      dec_cnt <= fire ? '0 : dec_cnt + 1'b1;
    end
  end

  assign stage_mask = STAGES'(1) << stage;
  assign done_cur   = |(stageDone & stage_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      stage <= '0;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      stage <= stage_nxt;
      wd    <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    stage_nxt      = stage;
    wd_nxt         = wd;
    frame_done_nxt = 1'b0;
    timeout_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = START;
          stage_nxt = '0;
        end
      end
      START: begin
        state_nxt = WAIT;
        wd_nxt    = WD_PRELOAD;
      end
      WAIT: begin
        // A completion arriving on the watchdog's last cycle still counts.
        if (done_cur) begin
          if (stage == LAST_STAGE) begin
            state_nxt      = IDLE;
            frame_done_nxt = 1'b1;
          end else begin
            state_nxt = START;
            stage_nxt = stage + 1'b1;
          end
        end else if (wd == '1) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stageStart <= '0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      stageStart <= (state_nxt == START) ? (STAGES'(1) << stage_nxt) : '0;
      busy       <= (state_nxt != IDLE);
      frameDone  <= frame_done_nxt;
    end
  end

  // A clear wins over a drop or timeout landing in the same cycle; that event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropCount    <= '0;
      timeoutErr   <= 1'b0;
      timeoutStage <= '0;
    end else if (clearErr) begin
      dropCount    <= '0;
      timeoutErr   <= 1'b0;
      timeoutStage <= '0;
    end else begin
      if (drop && (dropCount != '1)) begin
        dropCount <= dropCount + 1'b1;
      end
      if (timeout_hit) begin
        timeoutErr   <= 1'b1;
        timeoutStage <= stage;
      end
    end
  end

endmodule

// File: tb/tb_cc_frame_sequencer.sv
// Scoreboard bench for cc_frame_sequencer: a time-stamped reference model predicts
// start/done/timeout events and status levels; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_cc_frame_sequencer;

  localparam int STAGES    = 3;
  localparam int DELAY     = 4;
  localparam int DECIM_W   = 4;
  localparam int TIMEOUT_W = 6;
  localparam int CNT_W     = 4;
  localparam int STAGE_W   = 2;
  localparam int DEADLINE  = (1 << TIMEOUT_W) - 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               trigger = 1'b0;
  logic               enable = 1'b0;
  logic [DECIM_W-1:0] decimate = '0;
  logic [STAGES-1:0]  stage_done = '0;
  logic               clear_err = 1'b0;
  logic [STAGES-1:0]  stage_start;
  logic               busy;
  logic               frame_done;
  logic [CNT_W-1:0]   drop_count;
  logic               timeout_err;
  logic [STAGE_W-1:0] timeout_stage;

  cc_frame_sequencer #(
    .STAGES(STAGES), .DELAY(DELAY), .DECIM_W(DECIM_W),
    .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .enable(enable),
    .decimate(decimate), .stageDone(stage_done), .clearErr(clear_err),
    .stageStart(stage_start), .busy(busy), .frameDone(frame_done),
    .dropCount(drop_count), .timeoutErr(timeout_err), .timeoutStage(timeout_stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // kind: 0 = stage start, 1 = frame done, 2 = timeout flag rising
  typedef struct {
    int kind;
    int stage;
    int cyc_at;
  } ev_t;
  ev_t exp_q[$];

  bit dline[$];
  int m_dec_cnt, m_cur, m_start_cyc, m_done_cyc, m_drop, m_tstage;
  bit m_err;
  int exp_busy, exp_drop, exp_err, exp_tstage;

  bit noise_on = 0;
  int fixed_lat = 3;
  int stall_stage = -1;
  int stall_lat = 0;

  int last_start[STAGES];
  int last_fdone = -1;
  int last_to = -1;
  int frame_cnt = 0;
  bit prev_err = 0;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    dline.delete();
    for (int i = 0; i < DELAY; i++) dline.push_back(1'b0);
    m_dec_cnt = 0; m_cur = -1; m_start_cyc = 0; m_done_cyc = 0;
    m_drop = 0; m_err = 0; m_tstage = 0;
    exp_busy = 0; exp_drop = 0; exp_err = 0; exp_tstage = 0;
  endtask

  task automatic startStage(input int c);
    int lat;
    m_start_cyc = c;
    if (m_cur == stall_stage) lat = stall_lat;
    else if (fixed_lat > 0) lat = fixed_lat;
    else lat = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(1, 6));
    m_done_cyc = c + lat;
    exp_q.push_back('{kind: 0, stage: m_cur, cyc_at: c});
  endtask

  // Drives one cycle of inputs and advances the reference model to the next cycle.
  task automatic applyStimulus(input bit trig, input bit clr);
    bit [STAGES-1:0] done_v;
    bit dt, fire, busy_now;
    int n;
    n = cyc;
    exp_busy = (m_cur >= 0) ? 1 : 0;
    exp_drop = m_drop;
    exp_err = m_err;
    exp_tstage = m_tstage;
    done_v = '0;
    if (noise_on && $urandom_range(0, 3) == 0) done_v = STAGES'($urandom);
    if (m_cur >= 0 && n != m_start_cyc) done_v[m_cur] = (n == m_done_cyc);
    trigger = trig;
    clear_err = clr;
    stage_done = done_v;

    if (DELAY == 0) dt = trig;
    else begin
      dt = dline.pop_front();
      dline.push_back(trig);
    end
    fire = 0;
    if (!enable) m_dec_cnt = 0;
    else if (dt) begin
      if (m_dec_cnt >= int'(decimate)) begin
        fire = 1;
        m_dec_cnt = 0;
      end else m_dec_cnt++;
    end

    busy_now = (m_cur >= 0);
    if (busy_now) begin
      if (n > m_start_cyc && done_v[m_cur]) begin
        if (m_cur < STAGES - 1) begin
          m_cur++;
          startStage(n + 1);
        end else begin
          m_cur = -1;
          exp_q.push_back('{kind: 1, stage: 0, cyc_at: n + 1});
        end
      end else if (n == m_start_cyc + DEADLINE) begin
        if (!clr) begin
          if (!m_err) exp_q.push_back('{kind: 2, stage: m_cur, cyc_at: n + 1});
          m_err = 1;
          m_tstage = m_cur;
        end
        m_cur = -1;
      end
    end else if (fire) begin
      m_cur = 0;
      startStage(n + 1);
    end

    if (clr) begin
      m_drop = 0; m_err = 0; m_tstage = 0;
    end else if (fire && busy_now && m_drop < CNT_MAX) m_drop++;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic resetMid();
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_stage_start", stage_start, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_frame_done", frame_done, 0);
    checkOutput("arst_drop_count", drop_count, 0);
    checkOutput("arst_timeout_err", timeout_err, 0);
    checkOutput("arst_timeout_stage", timeout_stage, 0);
    modelReset();
    trigger = 1'b0; stage_done = '0; clear_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected events when the DUT presents them and checks status levels.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) prev_err = 1'b0;
    else begin
      while (exp_q.size() > 0 && exp_q[0].cyc_at < cyc) begin
        e = exp_q.pop_front();
        checkOutput("missed_event_cycle", cyc, e.cyc_at);
      end
      if (stage_start != '0) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 0) checkOutput("unexpected_start", stage_start, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("start_cycle", cyc, e.cyc_at);
          checkOutput("start_vector", stage_start, 1 << e.stage);
          last_start[e.stage] = cyc;
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 1) checkOutput("unexpected_frame_done", frame_done, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("frame_done_cycle", cyc, e.cyc_at);
          frame_cnt++;
          last_fdone = cyc;
        end
      end
      if (timeout_err && !prev_err) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 2) checkOutput("unexpected_timeout", timeout_err, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("timeout_cycle", cyc, e.cyc_at);
          checkOutput("timeout_stage_event", timeout_stage, e.stage);
          last_to = cyc;
        end
      end
      prev_err = timeout_err;
      checkOutput("busy", busy, exp_busy);
      checkOutput("drop_count", drop_count, exp_drop);
      checkOutput("timeout_err", timeout_err, exp_err);
      checkOutput("timeout_stage", timeout_stage, exp_tstage);
    end
  end

  initial begin
    int t, c, fc0;
    for (int i = 0; i < STAGES; i++) last_start[i] = -1;
    modelReset();

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_stage_start", stage_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_drop_count", drop_count, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic chain timing, every stage done three cycles after its start.
    enable = 1'b1; decimate = '0; fixed_lat = 3;
    idle(3);
    t = cyc;
    applyStimulus(1'b1, 1'b0);
    idle(25);
    checkOutput("tp_start0", last_start[0], t + 5);
    checkOutput("tp_start1", last_start[1], t + 9);
    checkOutput("tp_start2", last_start[2], t + 13);
    checkOutput("tp_frame_done", last_fdone, t + 17);

    // Decimation by 3 over nine triggers.
    enable = 1'b0;
    idle(2);
    enable = 1'b1; decimate = DECIM_W'(2);
    fc0 = frame_cnt;
    for (int i = 0; i < 9; i++) begin
      t = cyc;
      applyStimulus(1'b1, 1'b0);
      idle(29);
    end
    checkOutput("decim_frames", frame_cnt - fc0, 3);
    checkOutput("decim_last_start", last_start[0], t + 5);

    // Watchdog on the last stage, then a normal frame afterwards.
    decimate = '0;
    applyStimulus(1'b0, 1'b1);
    stall_stage = 2; stall_lat = 1000;
    fc0 = frame_cnt;
    applyStimulus(1'b1, 1'b0);
    idle(85);
    checkOutput("wd_err", timeout_err, 1);
    checkOutput("wd_stage", timeout_stage, 2);
    checkOutput("wd_cycle", last_to, last_start[2] + (1 << TIMEOUT_W) - 1);
    checkOutput("wd_no_frame_done", frame_cnt, fc0);
    stall_stage = -1;
    t = cyc;
    applyStimulus(1'b1, 1'b0);
    idle(25);
    checkOutput("wd_restart", last_start[0], t + 5);
    checkOutput("wd_restart_frame", frame_cnt, fc0 + 1);

    // Drops while stage 1 stalls: saturation, then a clear that swallows a drop.
    applyStimulus(1'b0, 1'b1);
    stall_stage = 1; stall_lat = 58;
    applyStimulus(1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    idle(4);
    checkOutput("drop_saturated", drop_count, CNT_MAX);
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    idle(DELAY - 1);
    checkOutput("clear_cycle_busy", busy, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("clear_beats_drop", drop_count, 0);
    checkOutput("clear_timing", cyc, c + DELAY + 1);
    idle(40);
    stall_stage = -1;

    // Asynchronous reset in the middle of stage 1.
    stall_stage = 1; stall_lat = 1000;
    applyStimulus(1'b1, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b0);
    idle(13);
    checkOutput("pre_reset_busy", busy, 1);
    resetMid();
    stall_stage = -1;
    fc0 = frame_cnt;
    t = cyc;
    applyStimulus(1'b1, 1'b0);
    idle(25);
    checkOutput("post_reset_start", last_start[0], t + 5);
    checkOutput("post_reset_frame", frame_cnt, fc0 + 1);

    // Disable during stage 0: the frame finishes, disabled triggers do nothing.
    applyStimulus(1'b0, 1'b1);
    stall_stage = 0; stall_lat = 20;
    fc0 = frame_cnt;
    t = cyc;
    applyStimulus(1'b1, 1'b0);
    idle(7);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0);
      idle(2);
    end
    idle(20);
    enable = 1'b1;
    checkOutput("dis_frames", frame_cnt, fc0 + 1);
    checkOutput("dis_frame_done", last_fdone, t + 34);
    checkOutput("dis_no_drop", drop_count, 0);
    stall_stage = -1;

    // Randomized traffic.
    noise_on = 1; fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) decimate = DECIM_W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0);
    end
    noise_on = 0; enable = 1'b1;
    idle(150);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_frame_sequencer.md
# cc_frame_sequencer

Parametrised frame sequencer that replaces hard-wired start chaining between the DFT, NoteFinder, LinearVisualizer and LED driver. It delays the DFT sample-read strobe, optionally decimates it, then issues one start pulse per stage in order, waiting for each stage's done. It also provides frame-drop accounting, a per-stage watchdog and an enable gate. It sits in the top level between DFT `doingRead` and the downstream stage start/done pairs.

## Interface
- `STAGES`, 3: number of chained stages (1..8)
- `DELAY`, 4: cycles between `trigger` and the decimation check; 0 = no delay
- `DECIM_W`, 4: width of `decimate`
- `TIMEOUT_W`, 20: watchdog counter width; timeout = 2^TIMEOUT_W − 1 cycles
- `CNT_W`, 16: width of `dropCount`

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `trigger`  in  1  one-cycle frame strobe (DFT `doingRead`)
- `enable`  in  1  high = accept new frames
- `decimate`  in  DECIM_W  run a frame every decimate+1 delayed triggers
- `stageDone`  in  STAGES  per-stage completion pulse
- `clearErr`  in  1  clears `timeoutErr`, `timeoutStage`, `dropCount`
- `stageStart`  out  STAGES  one-hot one-cycle start pulses
- `busy`  out  1  frame in flight
- `frameDone`  out  1  one-cycle pulse after last stage done
- `dropCount`  out  CNT_W  saturating count of frames refused while busy
- `timeoutErr`  out  1  sticky watchdog flag
- `timeoutStage`  out  $clog2(STAGES) (min 1)  stage that timed out

## Operation
- Reset (async assert, sync-safe release): all outputs 0, delay line cleared, decimation counter 0, FSM IDLE.
- Delay line: `trigger` shifted through DELAY flops; its output is `dTrig`.
- Decimation: on `dTrig` with `enable`=1: if `decCnt` == `decimate` → `fire`, `decCnt`←0; else `decCnt`++. When `enable`=0, `dTrig` is ignored and `decCnt` is held at 0. `decimate` may change at any time and is compared live; if `decCnt` > new `decimate`, the next `dTrig` fires.
- FSM states:
  - IDLE: on `fire` → START(0).
  - START(k): assert `stageStart[k]` for exactly one cycle, clear watchdog → WAIT(k).
  - WAIT(k): on `stageDone[k]` → START(k+1) if k<STAGES−1, else assert `frameDone` → IDLE.
  - WAIT(k) on watchdog reaching all-ones → set `timeoutErr`, `timeoutStage`←k → IDLE (frame aborted, no `frameDone`).
- `busy` = (state ≠ IDLE).
- `fire` while `busy`=1 → frame dropped, `dropCount`++ (saturating at all-ones).
- `stageDone` bits for stages other than the current k, or asserted during START, are ignored.
- `clearErr` has priority over a same-cycle drop or timeout; the event in that cycle is lost.
- Disabling mid-frame does not abort; the in-flight frame completes.

## Timing
- `trigger` at cycle t, `decimate`=0, idle → `stageStart[0]` high at t+DELAY+1.
- `stageDone[k]` sampled high at cycle d → `stageStart[k+1]` at d+1, or `frameDone` at d+1 with `busy` low from d+1.
- `fire` in the same cycle as the last `stageDone` is dropped (`busy` still high that cycle).
- Minimum frame length STAGES×2 cycles; back-to-back frames need ≥1 IDLE cycle.
- Watchdog counts WAIT cycles only; timeout fires 2^TIMEOUT_W − 1 cycles after entering WAIT(k).
- All outputs are registered; no combinational input→output paths.

## Structure
- Add to the CCHW package: `SeqState` enum (IDLE, START, WAIT) and a `clog2min1` helper constant function.
- Sub-module `cc_trigger_delay` (parametrised DELAY shift register, DELAY=0 passthrough). Everything else lives in `cc_frame_sequencer`.
- The top instantiates it with STAGES=3: stages are NoteFinder, LinearVisualizer and LEDDriver2; `trigger`=`DoingSampleRead`.

## Test plan
- DELAY=4, `decimate`=0, trigger at cycle 10, each stage done 3 cycles after start → `stageStart` pulses at 15, 19, 23; `frameDone` at 27; `busy` high cycles 15–26.
- `decimate`=2, 9 triggers spaced 100 cycles apart → exactly 3 frames, started on the 3rd, 6th and 9th triggers.
- Trigger every 20 cycles while stage 1 never completes until cycle 200, TIMEOUT_W=20 → `dropCount` increments once per fire while busy; saturates at 0xFFFF when CNT_W=16 is forced.
- TIMEOUT_W=4, stage 2 never done → `timeoutErr`=1 and `timeoutStage`=2 fifteen cycles after `stageStart[2]`; no `frameDone`; next fire starts stage 0 normally.
- Assert `rst` low mid-WAIT(1) → all outputs 0 immediately (asynchronous); after release the sequencer is idle and the next trigger starts at stage 0.
- Deassert `enable` during WAIT(0) → current frame completes; triggers while disabled produce neither a frame nor a `dropCount` increment; `clearErr` in the same cycle as a drop → `dropCount`=0.
